// File: rtl/secded2_128_scrub_ctrl.sv
`timescale 1ns/1ps
// secded2_128_scrub_ctrl
// Background scrubber for a 137-bit SECDED2 code-word memory. It reads every
// address in turn and hands each word to the external decoder. Words with a
// corrected single-bit error are re-encoded and written back. The block also
// keeps saturating error counters and remembers the first uncorrectable
// address seen since the last start.
module secded2_128_scrub_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic              i_mem_gnt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [136:0]      i_mem_rdata,
  output logic              o_mem_wr,
  output logic [136:0]      o_mem_wdata,
  output logic [136:0]      o_dec_code,
  output logic              o_dec_en,
  input  logic [127:0]      i_dec_data,
  input  logic              i_dec_valid,
  input  logic              i_dec_corr,
  input  logic              i_dec_fatal,
  output logic [127:0]      o_enc_data,
  input  logic [136:0]      i_enc_code,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_corr_cnt,
  output logic [15:0]       o_fatal_cnt,
  output logic              o_fatal_flag,
  output logic [ADDR_W-1:0] o_fatal_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RDWAIT,
    S_DEC,
    S_DWAIT,
    S_WB,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

  state_t state_q;
  state_t state_d;

  // A word is written back only when it was corrected; an uncorrectable
  // word (even if the decoder also flags it correctable) is left untouched.
  logic dec_needs_wb;
  assign dec_needs_wb = i_dec_corr && !i_dec_fatal;

  // Next-state decode and the memory/decoder strobes.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    o_mem_rd = 1'b0;
    o_mem_wr = 1'b0;
    o_dec_en = 1'b0;
    o_done   = 1'b0;
    case (state_q)
      S_IDLE:   if (i_start) state_d = S_REQ;
      S_REQ: begin
        // Strobe only while granted; a missing grant simply retries next cycle.
        o_mem_rd = i_mem_gnt;
        if (i_mem_gnt) state_d = S_RDWAIT;
      end
      S_RDWAIT: state_d = S_DEC;
      S_DEC: begin
        o_dec_en = 1'b1;
        state_d  = S_DWAIT;
      end
      S_DWAIT: begin
        if (i_dec_valid) state_d = dec_needs_wb ? S_WB : S_NEXT;
      end
      S_WB: begin
        o_mem_wr = i_mem_gnt;
        if (i_mem_gnt) state_d = S_NEXT;
      end
      S_NEXT:   state_d = (o_mem_addr == LAST_ADDR) ? S_DONE : S_REQ;
      S_DONE: begin
        o_done  = 1'b1;
        state_d = i_cont ? S_REQ : S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  assign o_busy = (state_q != S_IDLE);

  // Write data is only meaningful in WB; keep the bus quiet otherwise.
  assign o_mem_wdata = (state_q == S_WB) ? i_enc_code : '0;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the clock edge, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Address walk plus the code word / corrected data holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_mem_addr <= '0;
      o_dec_code <= '0;
      o_enc_data <= '0;
    end else begin
      case (state_q)
        S_IDLE:   if (i_start) o_mem_addr <= '0;
        S_RDWAIT: o_dec_code <= i_mem_rdata;
        S_DWAIT:  if (i_dec_valid && dec_needs_wb) o_enc_data <= i_dec_data;
        S_NEXT:   if (o_mem_addr != LAST_ADDR) o_mem_addr <= o_mem_addr + 1'b1;
        S_DONE:   if (i_cont) o_mem_addr <= '0;
        default:  ;
      endcase
    end
  end

  // Error statistics: cleared by an accepted start and kept across
  // continuous-mode sweeps; counters stick at their maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_corr_cnt   <= '0;
      o_fatal_cnt  <= '0;
      o_fatal_flag <= 1'b0;
      o_fatal_addr <= '0;
    end else if (state_q == S_IDLE && i_start) begin
      o_corr_cnt   <= '0;
      o_fatal_cnt  <= '0;
      o_fatal_flag <= 1'b0;
      o_fatal_addr <= '0;
    end else if (state_q == S_DWAIT && i_dec_valid) begin
      if (i_dec_fatal) begin
        if (o_fatal_cnt != CNT_MAX) o_fatal_cnt <= o_fatal_cnt + 16'd1;
        if (!o_fatal_flag) begin
          o_fatal_flag <= 1'b1;
          o_fatal_addr <= o_mem_addr;
        end
      end else if (i_dec_corr) begin
        if (o_corr_cnt != CNT_MAX) o_corr_cnt <= o_corr_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/secded2_128_scrub_ctrl.md
# secded2_128_scrub_ctrl

Background memory scrubber for 128-bit data protected by the 137-bit SECDED2 code. It walks every address of a code-word memory, sends each word through the external `secded2_128_dec` decoder, and writes corrected words back through the external encoder. It keeps saturating correctable/uncorrectable error counters and records the first fatal address. It sits between the memory arbiter port and the decoder/encoder pair, and uses memory only when the arbiter grants access.

## Interface
- `ADDR_W`, 10, memory address width
- `DEPTH`, 1024, number of words scrubbed per sweep (≤ 2^ADDR_W)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `i_start` in 1: start-sweep pulse; honoured only in IDLE
- `i_cont` in 1: continuous mode; sampled in DONE
- `i_mem_gnt` in 1: arbiter grant for this cycle
- `o_mem_addr` out ADDR_W: word address
- `o_mem_rd` out 1: read strobe; read data arrives on the next cycle
- `i_mem_rdata` in 137: read code word
- `o_mem_wr` out 1: write strobe
- `o_mem_wdata` out 137: write-back code word
- `o_dec_code` out 137: code word to the decoder, held stable until the result arrives
- `o_dec_en` out 1: one-cycle decode request
- `i_dec_data` in 128: corrected data from the decoder
- `i_dec_valid` in 1: decoder result valid
- `i_dec_corr` in 1: single-bit error corrected; sampled with valid
- `i_dec_fatal` in 1: uncorrectable error; sampled with valid
- `o_enc_data` out 128: data to the encoder, held from DWAIT exit through WB
- `i_enc_code` in 137: encoder output, combinational from `o_enc_data`
- `o_busy` out 1: high in every state except IDLE
- `o_done` out 1: one-cycle pulse at the end of a sweep
- `o_corr_cnt` out 16: correctable errors, saturates at 16'hFFFF
- `o_fatal_cnt` out 16: uncorrectable errors, saturates at 16'hFFFF
- `o_fatal_flag` out 1: sticky; cleared by an accepted `i_start`
- `o_fatal_addr` out ADDR_W: address of the first fatal error since start

## Operation
- States: IDLE, REQ, RDWAIT, DEC, DWAIT, WB, NEXT, DONE.
- IDLE:
  - On `i_start`, clear both counters, `o_fatal_flag`, `o_fatal_addr` and the address, then go to REQ.
  - `i_start` in any other state is ignored.
- REQ: `o_mem_rd = i_mem_gnt` (combinational). Leave for RDWAIT in the cycle the grant is seen; otherwise stay in REQ. The address holds.
- RDWAIT: register `i_mem_rdata` into `o_dec_code`, then go to DEC.
- DEC: `o_dec_en = 1` for exactly one cycle, then go to DWAIT.
- DWAIT: wait for `i_dec_valid` with no timeout. On valid:
  - fatal: `o_fatal_cnt` +1 (saturating). If the flag was clear, set it and latch `o_fatal_addr`. Go to NEXT; no write.
  - corr and not fatal: `o_corr_cnt` +1 (saturating), register `i_dec_data` into `o_enc_data`, go to WB.
  - neither: go to NEXT.
- WB: `o_mem_wr = i_mem_gnt`, `o_mem_wdata = i_enc_code`, address unchanged. Leave for NEXT in the grant cycle.
- NEXT: if the address equals DEPTH-1, go to DONE; else address +1 and go to REQ.
- DONE: `o_done = 1`.
  - If `i_cont`, set the address to 0 and go to REQ. Counters and fatal status are not cleared.
  - Else go to IDLE.
- `o_mem_rd` and `o_mem_wr` are never high together.
- `o_mem_rd` and `o_mem_wr` are never high without `i_mem_gnt`.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `o_mem_addr`, `o_dec_code` and `o_enc_data` are 0.
- Reset mid-operation: return to IDLE immediately. Any pending write is dropped, and no strobe is asserted in the cycle after reset deasserts.
- Per word with grant always high and 1-cycle decoder latency:
  - Clean or fatal word: 5 cycles (REQ, RDWAIT, DEC, DWAIT, NEXT).
  - Corrected word: 6 cycles (adds WB).
- Sweep of N clean words: `o_done` is high 5N cycles after the accepted `i_start` edge, plus the DONE cycle.
- Each cycle with the grant low in REQ or WB adds exactly one cycle.
- A counter at 16'hFFFF stays at 16'hFFFF.
- If `i_dec_corr` and `i_dec_fatal` are both high, the word is treated as fatal.

## Test plan
- DEPTH=4, all-zero memory, grant held high, `i_start` → `o_mem_rd` at addresses 0,1,2,3 in order; `o_done` pulses once; both counters 0; `o_mem_wr` never asserted.
- Word at addr 2 = 137'h1000 (single error) → exactly one `o_mem_wr` at addr 2 with `o_mem_wdata` = 0; `o_corr_cnt` = 1; the sweep takes 21 cycles.
- Word at addr 1 = 137'h50000 (double error) → no write; `o_fatal_cnt` = 1; `o_fatal_flag` = 1; `o_fatal_addr` = 1.
- Grant low for 3 cycles while in REQ at addr 1 → `o_mem_rd` stays low for those cycles; address 1 is read exactly once, nothing skipped; `o_done` comes 3 cycles later than the no-stall case.
- `i_cont` = 1 with the single error at addr 2 persisting in memory for 2 sweeps → 2 `o_done` pulses; `o_corr_cnt` = 1, because the second sweep reads corrected data.
- `reset` asserted during WB → no write is issued; all outputs are 0 on the next edge; a fresh `i_start` restarts the sweep from address 0.
